fall_alert_responder: RTL and testbench
=======================================

// Module: fall_alert_responder
// PURPOSE
//  Consumer side of the FallingDetector output. Qualifies the fallDetected level,
//  latches a fall event with a sensor snapshot, delivers one alert word to the
//  caregiver link over a valid/ready handshake, waits for acknowledge, retries,
//  then escalates. Sits between FallingDetector and the alert/notification path.
// PARAMETERS
//  DEBOUNCE_CYCLES  4     consecutive high fallDetected samples needed to qualify (>=1)
//  ACK_TIMEOUT      1000  cycles in WAIT_ACK before a retry (>=2)
//  MAX_RETRIES      3     resends before escalation (0..3)
//  ID_W             8     patient identifier width
// PORTS
//  clk            in   1       single clock, all logic rising-edge
//  rst            in   1       synchronous, active-high reset
//  fallDetected   in   1       level from FallingDetector
//  fdSensorValue  in   8       sensor value, snapshotted at qualification
//  patientId      in   ID_W    static patient identifier
//  alertValid     out  1       alert word valid
//  alertReady     in   1       link accepts word when alertValid&alertReady
//  alertData      out  ID_W+8  {patientId, snapshot}
//  ackIn          in   1       caregiver acknowledge pulse
//  alarmActive    out  1       high from qualification until ack accepted
//  escalate       out  1       high in ESCALATE
//  retryCount     out  2       resends issued for current event
// BEHAVIOUR
//  - Reset (any state, mid-handshake included): state IDLE, all outputs 0, counters 0.
//  - IDLE: fallDetected=1 -> QUALIFY, debounce count=1 (DEBOUNCE_CYCLES=1 -> SEND directly).
//  - QUALIFY: each high sample increments count; a low sample -> IDLE, count 0.
//    On DEBOUNCE_CYCLES-th consecutive high: capture fdSensorValue, -> SEND.
//    alertValid/alarmActive rise the cycle after that sample.
//  - SEND: alertValid=1, alertData stable until alertValid&alertReady; then -> WAIT_ACK,
//    timer=0. fallDetected changes ignored once qualified. ackIn ignored in SEND.
//  - WAIT_ACK: timer increments per cycle. ackIn=1 -> REARM. timer==ACK_TIMEOUT-1 without ack:
//    retryCount<MAX_RETRIES -> retryCount+1, -> SEND (same snapshot); else -> ESCALATE.
//    ack and timeout in same cycle: ack wins.
//  - ESCALATE: escalate=1, alarmActive=1, no further sends; ackIn -> REARM.
//  - REARM: alarmActive=0, escalate=0, retryCount=0; stays until fallDetected=0, then IDLE
//    (one fall produces exactly one alert sequence).
//  - Timer width clog2(ACK_TIMEOUT); no wrap possible (cleared on every exit of WAIT_ACK).
// CONFIGURATION
//  - FALL_ALERT_CANCEL_EN defined: adds input cancelIn (1). cancelIn=1 in QUALIFY or
//    WAIT_ACK -> REARM; in SEND honoured only after the current handshake completes;
//    in ESCALATE ignored (ack required). cancel and ack same cycle: treated as ack.
//  - Undefined: no cancelIn port; only ackIn clears an event.
// STRUCTURE
//  - Package fall_alert_pkg: state enum {IDLE,QUALIFY,SEND,WAIT_ACK,ESCALATE,REARM},
//    SENSOR_W=8 constant, alert word typedef.
//  - Sub-module fall_debounce: consecutive-high counter, outputs qualify pulse.
//  - Top: FSM, snapshot register, timeout timer, retry counter.
// TESTING
//  1. fallDetected high 3 cycles then low (DEBOUNCE=4) -> alertValid never rises, state IDLE.
//  2. fallDetected high 4 cycles, fdSensorValue=8'h04, patientId=8'h2A, alertReady=1
//     -> alertValid 1 cycle, alertData=16'h2A04; ackIn after 10 cycles -> alarmActive 0.
//  3. alertReady held 0 for 20 cycles -> alertValid and alertData stable all 20 cycles.
//  4. No ack, ACK_TIMEOUT=8, MAX_RETRIES=2 -> resends at retryCount 1,2; then escalate=1;
//     ackIn -> escalate 0; fallDetected still 1 -> no new alert until it drops and rises.
//  5. rst pulse while in WAIT_ACK -> next cycle all outputs 0, state IDLE.
//  6. (CANCEL_EN) cancelIn in WAIT_ACK -> REARM, alarmActive 0; cancel+ack same cycle -> ack path.

Source files
------------

// File: rtl/fall_alert_pkg.sv
// -----------------------------------------------------------------------------
// fall_alert_pkg
// Shared types and constants for the fall alert responder.
//   state_t       : responder FSM states
//   SENSOR_W      : width of the FallingDetector sensor value
//   sensor_t      : sensor snapshot type
//   alert_word_t  : alert word layout {patient id, snapshot} for the default
//                   8-bit patient identifier
// -----------------------------------------------------------------------------
package fall_alert_pkg;

   localparam int SENSOR_W     = 8;
   localparam int DEFAULT_ID_W = 8;

   typedef logic [SENSOR_W-1:0] sensor_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_QUALIFY  = 3'd1,
      ST_SEND     = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_ESCALATE = 3'd4,
      ST_REARM    = 3'd5
   } state_t;

   typedef struct packed {
      logic [DEFAULT_ID_W-1:0] patient_id;
      sensor_t                 snapshot;
   } alert_word_t;

endpackage

// File: rtl/fall_debounce.sv
// -----------------------------------------------------------------------------
// fall_debounce
// Counts consecutive high samples of the fall level while armed and raises a
// single-cycle qualify pulse on the DEBOUNCE_CYCLES-th consecutive high sample.
// Ports:
//   clk        in  clock, rising edge
//   rst        in  synchronous active-high reset
//   i_arm      in  counting enabled (responder idle or qualifying)
//   i_level    in  raw fallDetected level
//   o_qualify  out high on the sample that completes the debounce run
// -----------------------------------------------------------------------------
module fall_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_arm,
   input  logic i_level,
   output logic o_qualify
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] r_count;

   // r_count holds the number of high samples already seen, so the current
   // sample completes the run when it equals DEBOUNCE_CYCLES-1. With
   // DEBOUNCE_CYCLES=1 this qualifies straight from a zero count.
   assign o_qualify = i_arm & i_level & (r_count == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (!i_arm || !i_level || o_qualify) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/fall_alert_responder.sv
// -----------------------------------------------------------------------------
// fall_alert_responder
// Qualifies the FallingDetector level, latches a fall event with a sensor
// snapshot, sends one alert word over valid/ready, waits for acknowledge,
// retries on timeout and finally escalates.
// Optional feature: define FALL_ALERT_CANCEL_EN to add the cancelIn input.
// Ports:
//   clk, rst        clock / synchronous active-high reset
//   fallDetected    fall level from FallingDetector
//   fdSensorValue   sensor value, snapshotted at qualification
//   patientId       static patient identifier
//   alertValid      alert word valid (out)
//   alertReady      link accepts word on alertValid & alertReady
//   alertData       {patientId, snapshot} (out)
//   ackIn           caregiver acknowledge pulse
//   cancelIn        (FALL_ALERT_CANCEL_EN only) cancel current event
//   alarmActive     high from qualification until the event is cleared (out)
//   escalate        high while escalated (out)
//   retryCount      resends issued for the current event (out)
// -----------------------------------------------------------------------------
module fall_alert_responder
   import fall_alert_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int ACK_TIMEOUT     = 1000,
   parameter int MAX_RETRIES     = 3,
   parameter int ID_W            = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fallDetected,
   input  logic [SENSOR_W-1:0]      fdSensorValue,
   input  logic [ID_W-1:0]          patientId,
   output logic                     alertValid,
   input  logic                     alertReady,
   output logic [ID_W+SENSOR_W-1:0] alertData,
   input  logic                     ackIn,
`ifdef FALL_ALERT_CANCEL_EN
   input  logic                     cancelIn,
`endif
   output logic                     alarmActive,
   output logic                     escalate,
   output logic [1:0]               retryCount
);

   localparam int               TMR_W     = $clog2(ACK_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

   state_t           r_state;
   state_t           w_next;
   logic [TMR_W-1:0] r_timer;
   logic [1:0]       r_retry;
   sensor_t          r_snapshot;
   logic [ID_W-1:0]  r_patient;

   logic w_qualify;
   logic w_handshake;
   logic w_timeout;
   logic w_cancel;       // cancel usable right now (QUALIFY / WAIT_ACK)
   logic w_cancel_send;  // cancel to apply when the SEND handshake completes

   fall_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .i_arm     (r_state == ST_IDLE || r_state == ST_QUALIFY),
      .i_level   (fallDetected),
      .o_qualify (w_qualify)
   );

`ifdef FALL_ALERT_CANCEL_EN
   // A cancel seen during SEND is remembered and acted on once the word has
   // gone out, so the link never sees a withdrawn valid.
   logic r_cancel_pend;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cancel_pend <= 1'b0;
      end else begin
         r_cancel_pend <= (r_state == ST_SEND) & (r_cancel_pend | cancelIn);
      end
   end

   assign w_cancel      = cancelIn;
   assign w_cancel_send = cancelIn | r_cancel_pend;
`else
   assign w_cancel      = 1'b0;
   assign w_cancel_send = 1'b0;
`endif

   assign w_handshake = alertValid & alertReady;
   assign w_timeout   = (r_timer == TMR_LAST);

   // NOTE: every output of this always_comb is given a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_qualify)         w_next = ST_SEND;
            else if (fallDetected) w_next = ST_QUALIFY;
         end
         ST_QUALIFY: begin
            if (w_cancel)           w_next = ST_REARM;
            else if (w_qualify)     w_next = ST_SEND;
            else if (!fallDetected) w_next = ST_IDLE;
         end
         ST_SEND: begin
            if (w_handshake) w_next = w_cancel_send ? ST_REARM : ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            // ack (or cancel, which is treated the same) beats a timeout
            if (ackIn || w_cancel) w_next = ST_REARM;
            else if (w_timeout)    w_next = (r_retry < RETRY_MAX) ? ST_SEND : ST_ESCALATE;
         end
         ST_ESCALATE: begin
            if (ackIn) w_next = ST_REARM;
         end
         ST_REARM: begin
            // one fall, one alert sequence: wait for the level to drop
            if (!fallDetected) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // NOTE: the snapshot registers are reset along with the control state so
   // alertData reads zero after reset, not a stale word from an old event.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_timer    <= '0;
         r_retry    <= '0;
         r_snapshot <= '0;
         r_patient  <= '0;
      end else begin
         r_state <= w_next;

         // cleared on every exit from WAIT_ACK, so it can never wrap
         if (r_state == ST_WAIT_ACK && w_next == ST_WAIT_ACK) r_timer <= r_timer + 1'b1;
         else                                                 r_timer <= '0;

         if (w_next == ST_REARM)                              r_retry <= '0;
         else if (r_state == ST_WAIT_ACK && w_next == ST_SEND) r_retry <= r_retry + 1'b1;

         if ((r_state == ST_IDLE || r_state == ST_QUALIFY) && w_next == ST_SEND) begin
            r_snapshot <= fdSensorValue;
            r_patient  <= patientId;
         end
      end
   end

   assign alertValid  = (r_state == ST_SEND);
   assign alarmActive = (r_state == ST_SEND) || (r_state == ST_WAIT_ACK) ||
                        (r_state == ST_ESCALATE);
   assign escalate    = (r_state == ST_ESCALATE);
   assign retryCount  = r_retry;
   assign alertData   = {r_patient, r_snapshot};

endmodule

// File: tb/tb_fall_alert_responder.sv
// -----------------------------------------------------------------------------
// tb_fall_alert_responder
// Directed stimulus with a scoreboard: each expected alert word is queued when
// the fall is stimulated, and a monitor pops and compares on every accepted
// alert word. Define FALL_ALERT_CANCEL_EN to include the cancel scenarios.
// DUT: DEBOUNCE_CYCLES=4, ACK_TIMEOUT=8, MAX_RETRIES=2, ID_W=8.
// -----------------------------------------------------------------------------
module tb_fall_alert_responder;
   import fall_alert_pkg::*;

   typedef struct {
      alert_word_t word;
      logic [1:0]  retry;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        fall;
   logic [7:0]  sens;
   logic [7:0]  pid;
   logic        valid;
   logic        ready;
   logic [15:0] data;
   logic        ack;
   logic        cancel;
   logic        alarm;
   logic        esc;
   logic [1:0]  retry;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   fall_alert_responder #(
      .DEBOUNCE_CYCLES(4),
      .ACK_TIMEOUT    (8),
      .MAX_RETRIES    (2),
      .ID_W           (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fallDetected  (fall),
      .fdSensorValue (sens),
      .patientId     (pid),
      .alertValid    (valid),
      .alertReady    (ready),
      .alertData     (data),
      .ackIn         (ack),
`ifdef FALL_ALERT_CANCEL_EN
      .cancelIn      (cancel),
`endif
      .alarmActive   (alarm),
      .escalate      (esc),
      .retryCount    (retry)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] s, input logic [1:0] r);
      exp_t e;
      e.word.patient_id = 8'h2A;
      e.word.snapshot   = s;
      e.retry           = r;
      exp_q.push_back(e);
   endtask

   // Monitor: an accepted word is the pre-edge valid & ready, seen on negedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && valid && ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_alert", 32'(data), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("alert_data", 32'(data), 32'(e.word));
               check("alert_retry", 32'(retry), 32'(e.retry));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic ok;
      int   cycles;

      rst = 1'b1; fall = 1'b0; sens = 8'h00; pid = 8'h2A;
      ready = 1'b0; ack = 1'b0; cancel = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("reset_valid", 32'(valid), 32'd0);
      check("reset_alarm", 32'(alarm), 32'd0);
      check("reset_escalate", 32'(esc), 32'd0);
      check("reset_retry", 32'(retry), 32'd0);
      check("reset_data", 32'(data), 32'd0);

      // 1: three high samples are one short of qualifying
      fall = 1'b1; sens = 8'h99;
      repeat (3) tick();
      fall = 1'b0;
      ok = 1'b1;
      repeat (8) begin
         tick();
         if (valid || alarm) ok = 1'b0;
      end
      check("short_pulse_no_alert", 32'(ok), 32'd1);

      // 2: four high samples qualify; word accepted immediately, then ack
      sens = 8'h04; ready = 1'b1; fall = 1'b1;
      push(8'h04, 2'd0);
      repeat (3) tick();
      check("valid_before_4th", 32'(valid), 32'd0);
      tick();
      check("valid_after_4th", 32'(valid), 32'd1);
      check("alarm_after_4th", 32'(alarm), 32'd1);
      tick();
      check("valid_one_cycle", 32'(valid), 32'd0);
      check("alarm_waiting", 32'(alarm), 32'd1);
      repeat (4) tick();
      ack = 1'b1; tick(); ack = 1'b0;
      check("ack_clears_alarm", 32'(alarm), 32'd0);
      tick();
      fall = 1'b0; tick();

      // 3: link stalls for 20 cycles; word must hold
      ready = 1'b0; sens = 8'h5C; fall = 1'b1;
      push(8'h5C, 2'd0); push(8'h5C, 2'd1); push(8'h5C, 2'd2);
      repeat (4) tick();
      sens = 8'hEE;  // later sensor changes must not reach the held word
      ok = 1'b1;
      repeat (20) begin
         tick();
         if (!valid || data !== 16'h2A5C) ok = 1'b0;
      end
      check("stall_hold_stable", 32'(ok), 32'd1);

      // 4: no ack -> two resends, then escalation 26 cycles after first accept
      ready = 1'b1;
      tick();
      cycles = 0;
      while (cycles < 100 && !esc) begin
         tick();
         cycles++;
      end
      check("escalate_latency", 32'(cycles), 32'd26);
      check("escalate_retry", 32'(retry), 32'd2);
      check("escalate_alarm", 32'(alarm), 32'd1);
      ok = 1'b1;
      repeat (5) begin
         tick();
         if (valid || !esc) ok = 1'b0;
      end
      check("escalate_no_resend", 32'(ok), 32'd1);
      ack = 1'b1; tick(); ack = 1'b0;
      check("ack_clears_escalate", 32'(esc), 32'd0);
      check("ack_clears_alarm2", 32'(alarm), 32'd0);
      check("ack_clears_retry", 32'(retry), 32'd0);
      ok = 1'b1;
      repeat (10) begin
         tick();
         if (valid || alarm) ok = 1'b0;
      end
      check("held_fall_no_realert", 32'(ok), 32'd1);
      fall = 1'b0; tick();
      fall = 1'b1; sens = 8'h77;
      push(8'h77, 2'd0);
      repeat (4) tick();
      check("new_fall_realerts", 32'(valid), 32'd1);
      tick();  // accepted (ready=1), now waiting for ack

      // 5: reset while waiting for ack
      tick();
      rst = 1'b1; fall = 1'b0;
      tick();
      rst = 1'b0;
      check("midrun_reset_valid", 32'(valid), 32'd0);
      check("midrun_reset_alarm", 32'(alarm), 32'd0);
      check("midrun_reset_esc", 32'(esc), 32'd0);
      check("midrun_reset_retry", 32'(retry), 32'd0);
      check("midrun_reset_data", 32'(data), 32'd0);
      tick();

`ifdef FALL_ALERT_CANCEL_EN
      // 6: cancel while waiting for ack, then cancel together with ack
      fall = 1'b1; sens = 8'h11;
      push(8'h11, 2'd0);
      repeat (4) tick();
      tick();
      tick();
      cancel = 1'b1; tick(); cancel = 1'b0;
      check("cancel_clears_alarm", 32'(alarm), 32'd0);
      check("cancel_retry", 32'(retry), 32'd0);
      fall = 1'b0; tick();
      fall = 1'b1; sens = 8'h22;
      push(8'h22, 2'd0);
      repeat (4) tick();
      tick();
      ack = 1'b1; cancel = 1'b1; tick(); ack = 1'b0; cancel = 1'b0;
      check("cancel_ack_alarm", 32'(alarm), 32'd0);
      check("cancel_ack_esc", 32'(esc), 32'd0);
      fall = 1'b0; tick();
`endif

      repeat (3) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
